grid_reader: RTL

GRID_READER -- requirements
Module: grid_reader

---
 rtl/grid_reader_pkg.sv | 27 ++
 rtl/grid_reader_if.sv | 37 +++
 rtl/grid_reader_cursor.sv | 50 +++++
 rtl/grid_reader.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/grid_reader_pkg.sv
// Shared placement definitions: data width, empty-cell marker, the reader
// FSM state encoding and a node-range helper used by the placement engine.
package placement_pkg;

  localparam int DW = 32;

  localparam logic signed [DW-1:0] EMPTY = -1;

  typedef enum logic [3:0] {
    IDLE,
    GRD_RD,
    GRD_WT,
    POS_RD,
    POS_WT,
    CHECK,
    EMIT,
    NEXT,
    DONE
  } state_e;

  // A node id only addresses the position RAMs when it lies in 0..nv-1.
  function automatic logic node_in_range(input logic signed [DW-1:0] node,
                                         input int nv);
    return (node >= 0) && (node < nv);
  endfunction

endpackage

// File: rtl/grid_reader_if.sv
// Bundle of the grid reader's memory ports and its output tuple stream.
// The master side is the reader; the slave side is the RAMs plus consumer.
interface grid_reader_if #(
  parameter int DW = 32
);

  logic                 grid_re;
  logic signed [DW-1:0] grid_addr;
  logic signed [DW-1:0] grid_dout;

  logic                 px_re;
  logic                 py_re;
  logic signed [DW-1:0] px_addr;
  logic signed [DW-1:0] py_addr;
  logic signed [DW-1:0] px_dout;
  logic signed [DW-1:0] py_dout;

  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_node;
  logic signed [DW-1:0] out_x;
  logic signed [DW-1:0] out_y;
  logic                 out_err;

  modport master (
    output grid_re, grid_addr, px_re, py_re, px_addr, py_addr,
           out_valid, out_node, out_x, out_y, out_err,
    input  grid_dout, px_dout, py_dout, out_ready
  );

  modport slave (
    input  grid_re, grid_addr, px_re, py_re, px_addr, py_addr,
           out_valid, out_node, out_x, out_y, out_err,
    output grid_dout, px_dout, py_dout, out_ready
  );

endinterface

// File: rtl/grid_reader_cursor.sv
// Grid cursor: tracks the current (x,y) cell and its linear address x*N+y,
// stepping y fastest and flagging the final cell of the grid.
module grid_cursor #(
  parameter int N  = 6,
  parameter int DW = placement_pkg::DW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_i,
  input  logic                 step_i,
  output logic signed [DW-1:0] x_o,
  output logic signed [DW-1:0] y_o,
  output logic signed [DW-1:0] cell_o,
  output logic                 last_o
);
  import placement_pkg::*;

  localparam logic signed [DW-1:0] LastIdx = DW'(N - 1);

  logic signed [DW-1:0] x_q;
  logic signed [DW-1:0] y_q;
  logic signed [DW-1:0] cell_q;

  // Walk the grid in address order; clear wins over step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q    <= '0;
      y_q    <= '0;
      cell_q <= '0;
    end else if (clear_i) begin
      x_q    <= '0;
      y_q    <= '0;
      cell_q <= '0;
    end else if (step_i) begin
      cell_q <= cell_q + DW'(1);
      if (y_q == LastIdx) begin
        y_q <= '0;
        x_q <= x_q + DW'(1);
      end else begin
        y_q <= y_q + DW'(1);
      end
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign cell_o = cell_q;
  assign last_o = (x_q == LastIdx) && (y_q == LastIdx);

endmodule

// File: rtl/grid_reader.sv
// Grid reader: scans every grid cell, looks up the position of each placed
// node and emits (node, x, y, err) tuples flagging misplaced or bad nodes.
// Note: reset is asynchronous and active-low.
module grid_reader #(
  parameter int N  = 6,
  parameter int NV = 9,
  parameter int DW = placement_pkg::DW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic signed [DW-1:0] placed_count_o,
  output logic                 err_sticky_o,
  grid_reader_if.master        bus
);
  import placement_pkg::*;

  localparam logic signed [DW-1:0] EmptyCell = DW'(EMPTY);

  state_e               state_q;
  logic signed [DW-1:0] node_q;
  logic signed [DW-1:0] px_q;
  logic signed [DW-1:0] py_q;
  logic                 grid_re_q;
  logic signed [DW-1:0] grid_addr_q;
  logic                 pos_re_q;
  logic signed [DW-1:0] pos_addr_q;
  logic                 out_valid_q;
  logic signed [DW-1:0] out_node_q;
  logic signed [DW-1:0] out_x_q;
  logic signed [DW-1:0] out_y_q;
  logic                 out_err_q;
  logic signed [DW-1:0] placed_q;
  logic                 err_sticky_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 cur_clear;
  logic                 cur_step;
  logic signed [DW-1:0] cur_x;
  logic signed [DW-1:0] cur_y;
  logic signed [DW-1:0] cur_cell;
  logic                 cur_last;

  assign cur_clear = (state_q == IDLE) && start_i;
  assign cur_step  = (state_q == NEXT) && !cur_last;

  grid_cursor #(
    .N  (N),
    .DW (DW)
  ) u_cursor (
    .clk     (clk),
    .reset   (reset),
    .clear_i (cur_clear),
    .step_i  (cur_step),
    .x_o     (cur_x),
    .y_o     (cur_y),
    .cell_o  (cur_cell),
    .last_o  (cur_last)
  );

  // Scan FSM; every output is a register loaded on the edge entering the state that shows it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      node_q       <= '0;
      px_q         <= '0;
      py_q         <= '0;
      grid_re_q    <= 1'b0;
      grid_addr_q  <= '0;
      pos_re_q     <= 1'b0;
      pos_addr_q   <= '0;
      out_valid_q  <= 1'b0;
      out_node_q   <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_err_q    <= 1'b0;
      placed_q     <= '0;
      err_sticky_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            placed_q     <= '0;
            err_sticky_q <= 1'b0;
            busy_q       <= 1'b1;
            grid_re_q    <= 1'b1;
            grid_addr_q  <= '0;
            state_q      <= GRD_RD;
          end
        end
        GRD_RD: begin
          grid_re_q <= 1'b0;
          state_q   <= GRD_WT;
        end
        GRD_WT: begin
          node_q <= bus.grid_dout;
          if (bus.grid_dout == EmptyCell) begin
            state_q <= NEXT;
          end else begin
            placed_q <= placed_q + DW'(1);
            if (node_in_range(bus.grid_dout, NV)) begin
              pos_re_q   <= 1'b1;
              pos_addr_q <= bus.grid_dout;
            end
            state_q <= POS_RD;
          end
        end
        POS_RD: begin
          pos_re_q <= 1'b0;
          if (pos_re_q) begin
            state_q <= POS_WT;
          end else begin
            out_node_q  <= node_q;
            out_x_q     <= EmptyCell;
            out_y_q     <= EmptyCell;
            out_err_q   <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= EMIT;
          end
        end
        POS_WT: begin
          px_q    <= bus.px_dout;
          py_q    <= bus.py_dout;
          state_q <= CHECK;
        end
        CHECK: begin
          out_node_q  <= node_q;
          out_x_q     <= px_q;
          out_y_q     <= py_q;
          out_err_q   <= !((px_q == cur_x) && (py_q == cur_y));
          out_valid_q <= 1'b1;
          state_q     <= EMIT;
        end
        EMIT: begin
          if (bus.out_ready) begin
            out_valid_q  <= 1'b0;
            err_sticky_q <= err_sticky_q | out_err_q;
            state_q      <= NEXT;
          end
        end
        NEXT: begin
          if (cur_last) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            grid_re_q   <= 1'b1;
            grid_addr_q <= cur_cell + DW'(1);
            state_q     <= GRD_RD;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.grid_re   = grid_re_q;
  assign bus.grid_addr = grid_addr_q;
  assign bus.px_re     = pos_re_q;
  assign bus.py_re     = pos_re_q;
  assign bus.px_addr   = pos_addr_q;
  assign bus.py_addr   = pos_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_node  = out_node_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_err   = out_err_q;

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign placed_count_o = placed_q;
  assign err_sticky_o   = err_sticky_q;

endmodule
